// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and the status-flag bundle for param_sync_fifo and its bench.
package param_sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with occupancy flags and registered status pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almostfull,
    output logic                     almostempty,
    output logic                     wr_ack,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_LEVEL);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;
    fifo_flags_t           w_flags;

    always_comb begin
        w_flags             = '0;
        w_flags.full        = (r_count == C_DEPTH);
        w_flags.empty       = (r_count == '0);
        w_flags.almostfull  = (r_count >= C_AFULL);
        w_flags.almostempty = (r_count <= C_AEMPTY);
    end

    // Flush wins over both requests; gating acceptance keeps count inside 0..DEPTH.
    assign w_wr_acc = wr_en & ~w_flags.full  & ~flush;
    assign w_rd_acc = rd_en & ~w_flags.empty & ~flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en & w_flags.full  & ~flush;
            r_underflow <= rd_en & w_flags.empty & ~flush;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; reset forces the visible output to zero.
    assign data_out = rst ? '0 : w_rd_data;
`else
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_rd_data;
        end
    end

    assign data_out = r_dout;
`endif

    assign count       = r_count;
    assign full        = w_flags.full;
    assign empty       = w_flags.empty;
    assign almostfull  = w_flags.almostfull;
    assign almostempty = w_flags.almostempty;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; must be a power of two and at least 4.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-1: occupancy at or above which almostfull asserts.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 1: occupancy at or below which almostempty asserts.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port rd_en, input, 1 bit: read request.
REQ-009 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-010 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have ports full, empty, almostfull and almostempty, each an output of 1 bit: combinational occupancy flags.
REQ-014 SHALL have ports wr_ack, overflow and underflow, each an output of 1 bit: registered request-status pulses.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and full=0; the word is stored at wr_ptr and wr_ptr advances, wrapping DEPTH-1 -> 0.
REQ-016 A read SHALL be accepted when rd_en=1 and empty=0; rd_ptr advances with the same wrap rule.
REQ-017 When both wr_en=1 and rd_en=1 with 0<count<DEPTH, both SHALL be accepted and count SHALL stay unchanged.
REQ-018 When both are requested and full=1, only the read SHALL be accepted (count decrements); wr_ack stays 0 and overflow pulses.
REQ-019 When both are requested and empty=1, only the write SHALL be accepted (count increments); underflow pulses.
REQ-020 Flag definitions: full = (count==DEPTH); empty = (count==0); almostfull = (count>=AFULL_LEVEL); almostempty = (count<=AEMPTY_LEVEL).
REQ-021 wr_ack SHALL be 1 for exactly the cycle after an accepted write, otherwise 0.
REQ-022 overflow SHALL be 1 for the cycle after a cycle with wr_en=1 and full=1 in which the write was rejected.
REQ-023 underflow SHALL be 1 for the cycle after a cycle with rd_en=1 and empty=1.
REQ-024 Without FIFO_FWFT_EN, data_out SHALL be registered and updated to mem[rd_ptr] on an accepted read, so it is valid 1 cycle after the read edge; otherwise it holds its value.
REQ-025 flush=1 SHALL take priority over wr_en and rd_en and, on the clock edge, clear both pointers and count to 0; status pulses are 0 in the following cycle, and data_out holds its value.
REQ-026 count arithmetic SHALL never wrap: it stays within 0..DEPTH under all input combinations.

Reset
REQ-027 While rst=1, irrespective of clk, the block SHALL hold wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0 and underflow=0, giving empty=1, almostempty=1, full=0 and almostfull=0.
REQ-028 Storage contents need not be cleared by reset; a reset asserted mid-operation SHALL discard all entries.

Configuration
REQ-029 With macro FIFO_FWFT_EN defined, the block SHALL operate first-word-fall-through: data_out = mem[rd_ptr] combinationally, valid whenever empty=0, and an accepted rd_en pops the head entry.
REQ-030 Without FIFO_FWFT_EN, the block SHALL use the standard registered read of REQ-024.

Structure
REQ-031 The shared package SHALL hold the default DATA_WIDTH and DEPTH constants and a typedef for the status-flag bundle, reused by the bench.
REQ-032 Storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port; pointers, count and flags remain in param_sync_fifo.

Verification (DATA_WIDTH=16, DEPTH=8, AFULL_LEVEL=7, AEMPTY_LEVEL=1, without FIFO_FWFT_EN unless stated)
REQ-033 After reset, write 8 words 0x0001..0x0008 -> wr_ack pulses 8 times, almostfull asserts at count=7, full asserts at count=8; a 9th write -> overflow=1 for one cycle and count stays 8.
REQ-034 Read 8 words from full -> data_out sequence 0x0001..0x0008, each appearing 1 cycle after its read edge; empty=1 at the end; a further read -> underflow=1 and data_out holds 0x0008.
REQ-035 Simultaneous wr_en and rd_en at count=8 -> count goes to 7 and overflow=1; at count=0 -> count goes to 1 and underflow=1; at count=4 -> count stays 4.
REQ-036 Run 20 write/read cycles at steady count=3 -> pointers wrap past 7 -> 0 and data order is preserved.
REQ-037 Assert flush at count=5 together with wr_en=1 -> count=0 and empty=1 next cycle, with wr_ack=0; assert rst asynchronously mid-burst -> all outputs at reset values immediately.
REQ-038 With FIFO_FWFT_EN defined, write 0xABCD into an empty FIFO -> data_out=0xABCD in the cycle after the write, before any rd_en.
